// File: rtl/sc_nway_adder.sv
// ---------------------------------------------------------------------------
// sc_nway_adder
//
// Scaled stochastic adder for NUM_INPUTS unipolar bitstreams. The output
// stream carries P = (sum of input P) / NUM_INPUTS. It generalises the
// two-input toggle-flip-flop adder: a residue accumulator collects the
// popcount of each input sample and emits a 1 whenever NUM_INPUTS units have
// built up. The result is deterministic and does not depend on correlation
// between the inputs.
//
// Handshake: valid-only stream with no backpressure. A sample is consumed on
// every rising clk edge where in_valid=1 and clr=0. out/out_valid present
// the result of that sample one cycle later. A cycle with in_valid=0 is a
// bubble. clr takes priority over in_valid, and the sample presented with
// clr is discarded.
//
// Parameters:
//   NUM_INPUTS  number of input streams (>= 2)
//   RESET_SEED  residue value loaded on rst/clr (0..NUM_INPUTS-1)
//   CW          derived residue/sum width, $clog2(2*NUM_INPUTS)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   clr        in   synchronous clear of the residue, active-high
//   in_valid   in   x holds one valid bit per stream this cycle
//   x          in   one stochastic bit per input stream
//   out        out  registered output stream bit
//   out_valid  out  out is valid this cycle
//   residue    out  current residue register (debug visibility)
// ---------------------------------------------------------------------------
module sc_nway_adder #(
  parameter int NUM_INPUTS = 4,
  parameter int RESET_SEED = 0,
  localparam int CW = $clog2(2 * NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [NUM_INPUTS-1:0] x,
  output logic                  out,
  output logic                  out_valid,
  output logic [CW-1:0]         residue
);

  generate
    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("sc_nway_adder: NUM_INPUTS must be >= 2");
    end
    if ((RESET_SEED < 0) || (RESET_SEED >= NUM_INPUTS)) begin : g_bad_seed
      $error("sc_nway_adder: RESET_SEED must be in 0..NUM_INPUTS-1");
    end
  endgenerate

  // The threshold is the full constant NUM_INPUTS, so non-power-of-two
  // stream counts work without any bit-slice tricks.
  localparam logic [CW-1:0] N_C    = CW'(NUM_INPUTS);
  localparam logic [CW-1:0] SEED_C = CW'(RESET_SEED);

  logic [CW-1:0] p;   // popcount of x, 0..NUM_INPUTS
  logic [CW-1:0] s;   // residue + p, always < 2*NUM_INPUTS

  always_comb begin
    p = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      p = p + CW'(x[i]);
    end
    // residue < NUM_INPUTS and p <= NUM_INPUTS, so s fits in CW bits.
    s = residue + p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      residue   <= SEED_C;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      residue   <= SEED_C;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      // At most one 1 per cycle: s < 2*NUM_INPUTS means a single subtract
      // always brings the residue back below NUM_INPUTS.
      if (s >= N_C) begin
        out     <= 1'b1;
        residue <= s - N_C;
      end else begin
        out     <= 1'b0;
        residue <= s;
      end
      out_valid <= 1'b1;
    end else begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_nway_adder.sv
// ---------------------------------------------------------------------------
// tb_sc_nway_adder
//
// Bench for sc_nway_adder. Four instances with different NUM_INPUTS/seed
// share one clock; each has its own reset and inputs so stimulus for one
// never disturbs another. Directed samples push hand-computed
// {out, residue} pairs into a per-instance queue; monitors pop and compare
// whenever out_valid is seen. The N=5 instance runs a long random stream
// and is checked by conservation of ones and the final residue.
// ---------------------------------------------------------------------------
module tb_sc_nway_adder;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst2, clr2, in_valid2, out2, out_valid2;
  logic [1:0] x2;
  logic [1:0] residue2;

  logic       rst3, clr3, in_valid3, out3, out_valid3;
  logic [2:0] x3;
  logic [2:0] residue3;

  logic       rst4, clr4, in_valid4, out4, out_valid4;
  logic [3:0] x4;
  logic [2:0] residue4;

  logic       rst5, clr5, in_valid5, out5, out_valid5;
  logic [4:0] x5;
  logic [3:0] residue5;

  localparam int SEED5 = 3;

  sc_nway_adder #(.NUM_INPUTS(2), .RESET_SEED(0)) u2 (
    .clk(clk), .rst(rst2), .clr(clr2), .in_valid(in_valid2), .x(x2),
    .out(out2), .out_valid(out_valid2), .residue(residue2)
  );

  sc_nway_adder #(.NUM_INPUTS(3), .RESET_SEED(2)) u3 (
    .clk(clk), .rst(rst3), .clr(clr3), .in_valid(in_valid3), .x(x3),
    .out(out3), .out_valid(out_valid3), .residue(residue3)
  );

  sc_nway_adder #(.NUM_INPUTS(4), .RESET_SEED(0)) u4 (
    .clk(clk), .rst(rst4), .clr(clr4), .in_valid(in_valid4), .x(x4),
    .out(out4), .out_valid(out_valid4), .residue(residue4)
  );

  sc_nway_adder #(.NUM_INPUTS(5), .RESET_SEED(SEED5)) u5 (
    .clk(clk), .rst(rst5), .clr(clr5), .in_valid(in_valid5), .x(x5),
    .out(out5), .out_valid(out_valid5), .residue(residue5)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [4:0] exp_q2[$];
  logic [4:0] exp_q3[$];
  logic [4:0] exp_q4[$];
  logic [4:0] e2, e3, e4;
  int ones5   = 0;
  int valids5 = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst2 && out_valid2) begin
      if (exp_q2.size() == 0) check("u2_spurious_valid", out_valid2, 0);
      else begin
        e2 = exp_q2.pop_front();
        check("u2_out", out2, e2[4]);
        check("u2_residue", residue2, e2[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst3 && out_valid3) begin
      if (exp_q3.size() == 0) check("u3_spurious_valid", out_valid3, 0);
      else begin
        e3 = exp_q3.pop_front();
        check("u3_out", out3, e3[4]);
        check("u3_residue", residue3, e3[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4 && out_valid4) begin
      if (exp_q4.size() == 0) check("u4_spurious_valid", out_valid4, 0);
      else begin
        e4 = exp_q4.pop_front();
        check("u4_out", out4, e4[4]);
        check("u4_residue", residue4, e4[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst5) begin
      check("u5_residue_bound", (residue5 < 4'd5), 1);
      if (out_valid5) begin
        valids5++;
        if (out5) ones5++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks: inputs change on the falling edge, captured on the next
  // rising edge. Accepted samples push their expected result.
  // -------------------------------------------------------------------------
  task automatic step2(input logic [1:0] xv, input logic v,
                       input logic e_out, input logic [3:0] e_res);
    @(negedge clk);
    x2 = xv; in_valid2 = v; clr2 = 1'b0;
    if (v) exp_q2.push_back({e_out, e_res});
  endtask

  task automatic step3(input logic [2:0] xv, input logic v, input logic c,
                       input logic e_out, input logic [3:0] e_res);
    @(negedge clk);
    x3 = xv; in_valid3 = v; clr3 = c;
    if (v && !c) exp_q3.push_back({e_out, e_res});
  endtask

  task automatic step4(input logic [3:0] xv, input logic v,
                       input logic e_out, input logic [3:0] e_res);
    @(negedge clk);
    x4 = xv; in_valid4 = v; clr4 = 1'b0;
    if (v) exp_q4.push_back({e_out, e_res});
  endtask

  // Check a bubble result just after the edge that processed it.
  task automatic peek4(input logic [2:0] res);
    @(posedge clk);
    #2;
    check("u4_bubble_valid", out_valid4, 0);
    check("u4_bubble_residue_hold", residue4, res);
  endtask

  task automatic peek3(input logic [2:0] res);
    @(posedge clk);
    #2;
    check("u3_clr_valid", out_valid3, 0);
    check("u3_clr_residue", residue3, res);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int sum_p5 = 0;
  int acc5   = 0;

  initial begin
    rst2 = 0; rst3 = 0; rst4 = 0; rst5 = 0;
    clr2 = 0; clr3 = 0; clr4 = 0; clr5 = 0;
    in_valid2 = 0; in_valid3 = 0; in_valid4 = 0; in_valid5 = 0;
    x2 = '0; x3 = '0; x4 = '0; x5 = '0;
    #1;
    rst2 = 1; rst3 = 1; rst4 = 1; rst5 = 1;
    repeat (2) @(negedge clk);

    // Reset state: residue at seed, outputs low.
    check("rst_u4_residue", residue4, 0);
    check("rst_u4_out", out4, 0);
    check("rst_u4_out_valid", out_valid4, 0);
    check("rst_u3_residue", residue3, 2);
    check("rst_u5_residue", residue5, SEED5);
    check("rst_u2_out_valid", out_valid2, 0);
    rst2 = 0; rst3 = 0; rst4 = 0; rst5 = 0;

    // N=4, all ones: out=1 every cycle, residue stays 0.
    repeat (8) step4(4'b1111, 1'b1, 1'b1, 4'd0);

    // N=4, one input high: residue 1,2,3,0; out 0,0,0,1.
    for (int i = 0; i < 8; i++)
      step4(4'b0001, 1'b1, (i % 4 == 3), 4'((i + 1) % 4));

    // N=4, in_valid 1,0,1,0,1,0,1: residue holds in the gaps.
    step4(4'b0001, 1'b1, 1'b0, 4'd1);
    step4(4'b0001, 1'b0, 1'b0, 4'd0);
    peek4(3'd1);
    step4(4'b0001, 1'b1, 1'b0, 4'd2);
    step4(4'b0001, 1'b0, 1'b0, 4'd0);
    peek4(3'd2);
    step4(4'b0001, 1'b1, 1'b0, 4'd3);
    step4(4'b0001, 1'b0, 1'b0, 4'd0);
    peek4(3'd3);
    step4(4'b0001, 1'b1, 1'b1, 4'd0);
    step4(4'b0000, 1'b0, 1'b0, 4'd0);

    // N=2: TFF-adder equivalence, out 0,1,0,1,1,1.
    step2(2'b01, 1'b1, 1'b0, 4'd1);
    step2(2'b01, 1'b1, 1'b1, 4'd0);
    step2(2'b01, 1'b1, 1'b0, 4'd1);
    step2(2'b01, 1'b1, 1'b1, 4'd0);
    step2(2'b11, 1'b1, 1'b1, 4'd0);
    step2(2'b11, 1'b1, 1'b1, 4'd0);
    step2(2'b00, 1'b0, 1'b0, 4'd0);

    // N=3 seed 2: 2+1=3 -> out 1, residue 0; clr with in_valid discards
    // the sample and reloads 2; next sample 2+1=3 -> out 1, residue 0.
    step3(3'b001, 1'b1, 1'b0, 1'b1, 4'd0);
    step3(3'b001, 1'b1, 1'b1, 1'b0, 4'd0);
    peek3(3'd2);
    step3(3'b001, 1'b1, 1'b0, 1'b1, 4'd0);

    // N=3 async reset mid-run: sample 0+3 -> out 1, residue 0, then rst
    // between edges must clear outputs and load the seed at once.
    @(negedge clk);
    x3 = 3'b111; in_valid3 = 1'b1; clr3 = 1'b0;
    @(posedge clk);
    #2;
    check("u3_pre_rst_valid", out_valid3, 1);
    check("u3_pre_rst_out", out3, 1);
    in_valid3 = 1'b0;
    rst3 = 1'b1;
    #1;
    check("u3_async_rst_out", out3, 0);
    check("u3_async_rst_valid", out_valid3, 0);
    check("u3_async_rst_residue", residue3, 2);
    @(negedge clk);
    rst3 = 1'b0;
    step3(3'b001, 1'b1, 1'b0, 1'b1, 4'd0);
    step3(3'b000, 1'b0, 1'b0, 1'b0, 4'd0);

    // N=5 random stream, ~75% valid.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      x5 = 5'($urandom_range(0, 31));
      in_valid5 = ($urandom_range(0, 3) != 0);
      if (in_valid5) begin
        sum_p5 += $countones(x5);
        acc5++;
      end
    end
    @(negedge clk);
    in_valid5 = 1'b0;
    repeat (3) @(negedge clk);

    check("u5_valid_count", valids5, acc5);
    check("u5_ones_conservation", ones5, (SEED5 + sum_p5) / 5);
    check("u5_final_residue", residue5, (SEED5 + sum_p5) % 5);

    check("u2_queue_drained", exp_q2.size(), 0);
    check("u3_queue_drained", exp_q3.size(), 0);
    check("u4_queue_drained", exp_q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
